// File: rtl/div_sched.sv
// div_sched: round-robin scheduler that shares one signed 64/32 divider between NREQ
// requesters and returns each result on a single valid/ready response channel.
// Optional feature macro: DIV_ZERO_BYPASS_EN. When defined, a zero-divisor request is
// answered directly (err=1, quo=all ones, rem=low dividend word) without touching the divider.
module div_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DIV_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*64-1:0] req_dnd,
  input  logic [NREQ*32-1:0] req_der,
  output logic [63:0]        div_dnd,
  output logic [31:0]        div_der,
  input  logic [31:0]        div_quo,
  input  logic [31:0]        div_rem,
  input  logic               div_err,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_quo,
  output logic [31:0]        rsp_rem,
  output logic               rsp_err,
  output logic               busy
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_gnt_id;
  logic [CntW-1:0] r_cnt;
  logic [63:0]     r_div_dnd;
  logic [31:0]     r_div_der;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [31:0]     r_rsp_quo;
  logic [31:0]     r_rsp_rem;
  logic            r_rsp_err;

  logic            w_gnt_vld;
  logic [ID_W-1:0] w_gnt_id;
  logic [ID_W-1:0] w_rr_next;
  logic [63:0]     w_gnt_dnd;
  logic [31:0]     w_gnt_der;
  logic            w_grant;
  logic            w_bypass;

  // Round-robin search: first valid requester starting at the rotating pointer.
  always_comb begin
    int unsigned v_idx;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    v_idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      v_idx = (32'(r_rr_ptr) + i) % NREQ;
      if (!w_gnt_vld && req_valid[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_W'(v_idx);
      end
    end
  end

  assign w_gnt_dnd = req_dnd[64*w_gnt_id +: 64];
  assign w_gnt_der = req_der[32*w_gnt_id +: 32];
  assign w_rr_next = (32'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;
  assign w_grant   = (r_state == StIdle) && w_gnt_vld;

`ifdef DIV_ZERO_BYPASS_EN
  assign w_bypass = (w_gnt_der == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Grant strobe: one-hot to the winner, only in IDLE; forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (w_grant && rst_n) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  // Scheduler FSM with all divider and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_cnt       <= '0;
      r_div_dnd   <= '0;
      r_div_der   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_quo   <= '0;
      r_rsp_rem   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_gnt_vld) begin
            r_rr_ptr <= w_rr_next;
            r_gnt_id <= w_gnt_id;
            if (w_bypass) begin
              // Zero divisor answered locally; divider operands keep their old value.
              r_rsp_quo   <= '1;
              r_rsp_rem   <= w_gnt_dnd[31:0];
              r_rsp_err   <= 1'b1;
              r_rsp_id    <= w_gnt_id;
              r_rsp_valid <= 1'b1;
              r_state     <= StResp;
            end else begin
              r_div_dnd <= w_gnt_dnd;
              r_div_der <= w_gnt_der;
              r_cnt     <= CntW'(DIV_LAT);
              r_state   <= StWait;
            end
          end
        end
        StWait: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_quo   <= div_quo;
            r_rsp_rem   <= div_rem;
            r_rsp_err   <= div_err;
            r_rsp_id    <= r_gnt_id;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign div_dnd   = r_div_dnd;
  assign div_der   = r_div_der;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_quo   = r_rsp_quo;
  assign rsp_rem   = r_rsp_rem;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: drives randomized requests, emulates the shared divider and checks
// grant order, latency and bit-exact results against an arithmetic reference model.
// Follows DIV_ZERO_BYPASS_EN in the same way as the design.
module tb_div_sched;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned DivLat = 1;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*64-1:0] req_dnd;
  logic [NREQ*32-1:0] req_der;
  logic [63:0]        div_dnd;
  logic [31:0]        div_der;
  logic [31:0]        div_quo;
  logic [31:0]        div_rem;
  logic               div_err;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_quo;
  logic [31:0]        rsp_rem;
  logic               rsp_err;
  logic               busy;

  int          total = 0;
  int          bad = 0;
  int          onehot_viol = 0;
  int          m_rr = 0;
  logic [63:0] m_dnd = '0;
  logic [31:0] m_der = '0;

  always #5 clk = ~clk;

  div_sched #(
    .NREQ   (NREQ),
    .ID_W   (ID_W),
    .DIV_LAT(DivLat)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dnd  (req_dnd),
    .req_der  (req_der),
    .div_dnd  (div_dnd),
    .div_der  (div_der),
    .div_quo  (div_quo),
    .div_rem  (div_rem),
    .div_err  (div_err),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_quo  (rsp_quo),
    .rsp_rem  (rsp_rem),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  // Signed 64/32 division; error on zero divisor or quotient outside 32-bit signed range.
  function automatic void div_ref(input logic [63:0] dnd, input logic [31:0] der,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    longint sd, sv, lq, lr;
    longint k_max;
    k_max = 2147483647;
    sd = $signed(dnd);
    sv = longint'($signed(der));
    q = '0; r = '0; e = 1'b1;
    if (sv == 0) return;
    if (dnd == 64'h8000_0000_0000_0000 && der == 32'hFFFF_FFFF) return;
    lq = sd / sv;
    lr = sd % sv;
    if (lq > k_max || lq < -k_max - 1) return;
    q = lq[31:0];
    r = lr[31:0];
    e = 1'b0;
  endfunction

  // Expected response and edges from grant edge to rsp_valid.
  function automatic void exp_rsp(input logic [63:0] dnd, input logic [31:0] der,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e, output int lat);
    if (Bypass && der == '0) begin
      q = 32'hFFFF_FFFF; r = dnd[31:0]; e = 1'b1; lat = 0;
    end else begin
      div_ref(dnd, der, q, r, e);
      lat = DivLat + 1;
    end
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(rr + i) % NREQ]) return (rr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rnd_dnd();
    logic [31:0] lo;
    lo = $urandom();
    if ($urandom_range(3) == 0) return {$urandom(), lo};
    return {{32{lo[31]}}, lo};
  endfunction

  function automatic logic [31:0] rnd_der();
    int unsigned s;
    s = $urandom_range(7);
    if (s == 0) return 32'h0;
    if (s == 1) return 32'hFFFF_FFFF;
    if (s < 4) return 32'($urandom_range(1, 100));
    return $urandom();
  endfunction

  // Shared divider emulation: DivLat-stage registered pipeline.
  logic [64:0] div_pipe [DivLat];
  always @(posedge clk) begin : p_div
    logic [31:0] q, r;
    logic        e;
    div_ref(div_dnd, div_der, q, r, e);
    div_pipe[0] <= {e, r, q};
    for (int i = 1; i < DivLat; i++) div_pipe[i] <= div_pipe[i-1];
  end
  assign {div_err, div_rem, div_quo} = div_pipe[DivLat-1];

  always @(negedge clk) begin
    if ($countones(req_ready) > 1) onehot_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [63:0] dnd, input logic [31:0] der);
    req_dnd[64*k +: 64] = dnd;
    req_der[32*k +: 32] = der;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_rr  = 0;
    m_dnd = '0;
    m_der = '0;
    tick();
  endtask

  // Returns at the sample point just before the grant edge.
  task automatic await_grant(output int gid, output bit to);
    int n;
    n = 0; gid = -1; to = 1'b0;
    #1;
    while (req_ready === '0 && n < 40) begin
      tick();
      n++;
    end
    if (req_ready === '0) to = 1'b1;
    else for (int i = 0; i < NREQ; i++) if (req_ready[i] && gid < 0) gid = i;
  endtask

  // Counts edges until rsp_valid; also counts samples with any req_ready high.
  task automatic await_rsp(output int lat, output bit to, output int leak);
    lat = 0; to = 1'b0; leak = 0;
    #1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (req_ready !== '0) leak++;
      tick();
      lat++;
    end
    if (rsp_valid !== 1'b1) to = 1'b1;
    if (req_ready !== '0) leak++;
  endtask

  task automatic test_reset();
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) set_req(k, 64'h1234, 32'h5);
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b/%b want=0/0", req_ready, busy);
    end
    total++;
    if (div_dnd !== '0 || div_der !== '0) begin
      bad++; $display("FAIL reset_div got=%h/%h want=0/0", div_dnd, div_der);
    end
    total++;
    if ({rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err} !== '0) begin
      bad++; $display("FAIL reset_rsp got=%b %h %h %h %b want=all0", rsp_valid, rsp_id,
                      rsp_quo, rsp_rem, rsp_err);
    end
    tick();
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    m_rr = 0; m_dnd = '0; m_der = '0;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      bad++; $display("FAIL idle_noreq got=%b/%b want=0/0", busy, req_ready);
    end
  endtask

  task automatic test_basic();
    int gid, lat, leak;
    bit to;
    set_req(0, 64'd100, 32'd7);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    await_grant(gid, to);
    total++;
    if (to || gid != 0) begin
      bad++; $display("FAIL basic_grant got=%0d to=%0b want=0", gid, to); req_valid = '0;
      return;
    end
    tick();
    req_valid = '0; m_rr = 1; m_dnd = 64'd100; m_der = 32'd7;
    #1;
    total++;
    if (req_ready !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_pulse got=%b/%b want=0000/1", req_ready, busy);
    end
    total++;
    if (div_dnd !== 64'd100 || div_der !== 32'd7) begin
      bad++; $display("FAIL basic_ops got=%0d/%0d want=100/7", div_dnd, div_der);
    end
    await_rsp(lat, to, leak);
    total++;
    if (to || lat != int'(DivLat) + 1) begin
      bad++; $display("FAIL basic_lat got=%0d want=%0d", lat, DivLat + 1);
    end
    total++;
    if (rsp_id !== 2'd0 || rsp_quo !== 32'd14 || rsp_rem !== 32'd2 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL basic_rsp got=%0d %0d %0d %b want=0 14 2 0", rsp_id, rsp_quo,
                      rsp_rem, rsp_err);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_done got=%b/%b want=0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int gid, lat, leak, el;
    bit to;
    logic [63:0] dnd;
    logic [31:0] der, eq, er;
    logic ee;
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < NREQ; k++) set_req(k, rnd_dnd(), rnd_der());
      await_grant(gid, to);
      total++;
      if (to || gid != n % NREQ) begin
        bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", n, gid, n % NREQ);
        req_valid = '0;
        return;
      end
      dnd = req_dnd[64*gid +: 64];
      der = req_der[32*gid +: 32];
      exp_rsp(dnd, der, eq, er, ee, el);
      tick();
      m_rr = (gid + 1) % NREQ;
      set_req(gid, rnd_dnd(), rnd_der());
      await_rsp(lat, to, leak);
      total++;
      if (to || lat != el || leak != 0) begin
        bad++; $display("FAIL rr_lat[%0d] got=%0d leak=%0d want=%0d", n, lat, leak, el);
      end
      total++;
      if (rsp_id !== ID_W'(gid) || rsp_quo !== eq || rsp_rem !== er || rsp_err !== ee) begin
        bad++; $display("FAIL rr_rsp[%0d] got=%0d %h %h %b want=%0d %h %h %b", n, rsp_id,
                        rsp_quo, rsp_rem, rsp_err, gid, eq, er, ee);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int gid, lat, leak;
    bit to;
    do_reset();
    set_req(2, 64'hFFFF_FFFF_FFFF_FF9C, 32'd7);
    req_valid = 4'b0100;
    await_grant(gid, to);
    total++;
    if (to || gid != 2) begin
      bad++; $display("FAIL bp_grant got=%0d want=2", gid); req_valid = '0;
      return;
    end
    tick();
    m_rr = 3;
    req_valid = 4'b0010;
    set_req(1, 64'd50, 32'd5);
    await_rsp(lat, to, leak);
    total++;
    if (to || lat != int'(DivLat) + 1 || leak != 0) begin
      bad++; $display("FAIL bp_lat got=%0d leak=%0d want=%0d", lat, leak, DivLat + 1);
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_quo !== 32'hFFFF_FFF2 ||
          rsp_rem !== 32'hFFFF_FFFE || rsp_err !== 1'b0 || req_ready !== '0) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b %0d %h %h %b rdy=%b want=1 2 fffffff2 fffffffe 0 0000",
                        c, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== '0) begin
      bad++; $display("FAIL bp_hs_nogrant got=%b want=0000", req_ready);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_hs got=%b want=0", rsp_valid);
    end
    await_grant(gid, to);
    total++;
    if (to || gid != pick(4'b0010, m_rr)) begin
      bad++; $display("FAIL bp_next_grant got=%0d want=1", gid); req_valid = '0;
      return;
    end
    tick();
    req_valid = '0;
    m_rr = 2;
    await_rsp(lat, to, leak);
    total++;
    if (to || rsp_id !== 2'd1 || rsp_quo !== 32'd10 || rsp_rem !== 32'd0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL bp_next_rsp got=%0d %0d %0d %b want=1 10 0 0", rsp_id, rsp_quo,
                      rsp_rem, rsp_err);
    end
    tick();
  endtask

  task automatic test_zero_div();
    int gid, lat, leak, el;
    bit to;
    logic [31:0] eq, er;
    logic ee;
    logic [63:0] want_dnd;
    logic [31:0] want_der;
    do_reset();
    set_req(1, 64'd5, 32'd0);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    exp_rsp(64'd5, 32'd0, eq, er, ee, el);
    await_grant(gid, to);
    total++;
    if (to || gid != 1) begin
      bad++; $display("FAIL zero_grant got=%0d want=1", gid); req_valid = '0;
      return;
    end
    tick();
    req_valid = '0;
    want_dnd = Bypass ? m_dnd : 64'd5;
    want_der = Bypass ? m_der : 32'd0;
    #1;
    total++;
    if (div_dnd !== want_dnd || div_der !== want_der) begin
      bad++; $display("FAIL zero_ops got=%h/%h want=%h/%h", div_dnd, div_der, want_dnd, want_der);
    end
    await_rsp(lat, to, leak);
    total++;
    if (to || lat != el) begin
      bad++; $display("FAIL zero_lat got=%0d want=%0d", lat, el);
    end
    total++;
    if (rsp_id !== 2'd1 || rsp_err !== 1'b1 || rsp_quo !== eq || rsp_rem !== er || busy !== 1'b1)
    begin
      bad++; $display("FAIL zero_rsp got=%0d %b %h %h busy=%b want=1 1 %h %h busy=1", rsp_id,
                      rsp_err, rsp_quo, rsp_rem, busy, eq, er);
    end
    rsp_ready = 1'b1;
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL zero_hs got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_mid_reset();
    int gid, lat, leak, seen;
    bit to;
    logic [31:0] eq, er;
    logic ee;
    int el;
    do_reset();
    set_req(2, 64'd1000, 32'd3);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    await_grant(gid, to);
    total++;
    if (to || gid != 2) begin
      bad++; $display("FAIL mr_grant got=%0d want=2", gid); req_valid = '0;
      return;
    end
    tick();
    req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, busy, div_dnd, div_der, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err} !== '0)
    begin
      bad++; $display("FAIL mr_clear got=%b %b %h %h %b %h %h %h %b want=all0", req_ready, busy,
                      div_dnd, div_der, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err);
    end
    tick();
    rst_n = 1'b1;
    m_rr = 0; m_dnd = '0; m_der = '0;
    seen = 0;
    repeat (DivLat + 4) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL mr_no_rsp got=%0d want=0", seen);
    end
    for (int k = 0; k < NREQ; k++) set_req(k, rnd_dnd(), 32'd9);
    req_valid = '1;
    await_grant(gid, to);
    total++;
    if (to || gid != 0) begin
      bad++; $display("FAIL mr_rr_restart got=%0d want=0", gid); req_valid = '0;
      return;
    end
    exp_rsp(req_dnd[63:0], req_der[31:0], eq, er, ee, el);
    tick();
    req_valid = '0;
    m_rr = 1;
    await_rsp(lat, to, leak);
    total++;
    if (to || rsp_id !== 2'd0 || rsp_quo !== eq || rsp_rem !== er || rsp_err !== ee) begin
      bad++; $display("FAIL mr_rsp got=%0d %h %h %b want=0 %h %h %b", rsp_id, rsp_quo, rsp_rem,
                      rsp_err, eq, er, ee);
    end
    tick();
  endtask

  task automatic test_random();
    int gid, lat, leak, el, eg, stall;
    bit to;
    logic [63:0] dnd;
    logic [31:0] der, eq, er;
    logic ee;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < NREQ; k++) set_req(k, rnd_dnd(), rnd_der());
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      eg = pick(req_valid, m_rr);
      await_grant(gid, to);
      total++;
      if (to || gid != eg) begin
        bad++; $display("FAIL rnd_grant[%0d] got=%0d want=%0d", n, gid, eg); req_valid = '0;
        return;
      end
      dnd = req_dnd[64*gid +: 64];
      der = req_der[32*gid +: 32];
      exp_rsp(dnd, der, eq, er, ee, el);
      stall = $urandom_range(0, 3);
      tick();
      m_rr = (gid + 1) % NREQ;
      if (!(Bypass && der == '0)) begin
        m_dnd = dnd; m_der = der;
      end
      // New requests raised during the transaction must wait for IDLE.
      req_valid = NREQ'($urandom());
      rsp_ready = (stall == 0);
      total++;
      if (div_dnd !== m_dnd || div_der !== m_der) begin
        bad++; $display("FAIL rnd_ops[%0d] got=%h/%h want=%h/%h", n, div_dnd, div_der, m_dnd,
                        m_der);
      end
      await_rsp(lat, to, leak);
      total++;
      if (to || lat != el || leak != 0) begin
        bad++; $display("FAIL rnd_lat[%0d] got=%0d leak=%0d want=%0d", n, lat, leak, el);
      end
      total++;
      if (rsp_id !== ID_W'(gid) || rsp_quo !== eq || rsp_rem !== er || rsp_err !== ee) begin
        bad++; $display("FAIL rnd_rsp[%0d] got=%0d %h %h %b want=%0d %h %h %b", n, rsp_id,
                        rsp_quo, rsp_rem, rsp_err, gid, eq, er, ee);
      end
      repeat (stall) begin
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_quo !== eq || rsp_rem !== er || req_ready !== '0) begin
          bad++; $display("FAIL rnd_stall[%0d] got=%b %h %h rdy=%b want=1 %h %h 0", n, rsp_valid,
                          rsp_quo, rsp_rem, req_ready, eq, er);
        end
      end
      rsp_ready = 1'b1;
      tick();
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL rnd_hs[%0d] got=%b want=0", n, rsp_valid);
      end
    end
    req_valid = '0;
    total++;
    if (onehot_viol != 0) begin
      bad++; $display("FAIL onehot got=%0d want=0", onehot_viol);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_dnd   = '0;
    req_der   = '0;
    #2;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_zero_div();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
